regfile_wb_queue: RTL
=====================

Name: regfile_wb_queue

Overview:
Writer-side companion to RegFile. It buffers completed results (rd, data) from execute/load units in an in-order FIFO and drains them one per cycle onto RegFile's write port (RegW/Rd/Wd). It also exposes a pending-write lookup with youngest-entry forwarding for the two read addresses, so decode can bypass or stall instead of reading stale RegFile contents. It sits between the execute/memory stages and RegFile.

Parameters:
DEPTH, 4, number of queue entries; power of two, minimum 2.
DATA_W, 32, register data width.
ADDR_W, 5, register index width (32 registers, x0 hardwired zero).

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset asserted).
in_valid  in  1  producer presents a result.
in_ready  out  1  queue can accept this cycle.
in_rd  in  ADDR_W  destination register.
in_data  in  DATA_W  result value.
wb_stall  in  1  1 = suppress drain this cycle (write port borrowed elsewhere).
RegW  out  1  RegFile write enable.
Rd  out  ADDR_W  RegFile write address.
Wd  out  DATA_W  RegFile write data.
q_rs1, q_rs2  in  ADDR_W  read addresses to check against pending writes.
q_hit1, q_hit2  out  1  a pending entry targets q_rsN.
fwd_data1, fwd_data2  out  DATA_W  data of the youngest matching entry; 0 when no hit.
count  out  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (rst=0, async): head, tail and count cleared, all entries invalid. RegW=0, Rd=0, Wd=0, q_hit*=0, fwd_data*=0, in_ready=1. A reset mid-operation discards queued entries. No write is issued during reset or on the first edge after release.
- Push: on an edge where in_valid && in_ready, the pair (in_rd, in_data) is written at tail and tail advances (wraps modulo DEPTH).
- x0 filter: in_rd==0 is handshaked (consumed) but not enqueued. count is unchanged.
- Drain (combinational from head): RegW = (count!=0) && !wb_stall; Rd and Wd = head entry when count!=0, otherwise 0. On an edge with RegW=1 the head is popped and head advances (wraps).
- in_ready = (count<DEPTH) || RegW. When full and draining, a push and a pop on the same edge are allowed and count stays DEPTH.
- Simultaneous push and pop at any occupancy: count is unchanged. The popped entry is the old head. The empty-queue case cannot pop.
- Latency: an entry accepted at edge N appears at the write port in cycle N+1 at the earliest, and reaches RegFile at edge N+1. There is no empty-queue bypass.
- Ordering: strictly in order. Multiple entries to the same rd all drain, so the last one wins in RegFile.
- Lookup (combinational, per read port): hit = q_rsN!=0 and some valid entry has rd==q_rsN. fwd_data = data of the youngest (nearest tail) matching entry. q_rsN==0 gives hit=0 and data=0. An entry being popped this cycle still counts as a hit; RegFile updates only at the edge.
- Lookup ignores the entry being pushed in the same cycle.
- count is a registered value, range 0..DEPTH.

Decomposition:
- Shared package: ADDR_W, DATA_W, NUM_REGS=32, ZERO_REG=0, and the typedef wbq_entry_t {rd, data}.
- One natural sub-module: wbq_match. It takes the entry array, valid mask, head pointer and query address, and returns hit plus youngest-match data. It is instantiated twice, once per read port.

Test Plan:
1. Reset, then release: RegW=0, count=0, in_ready=1. Assert rst=0 with 2 entries queued: count=0 and RegW=0 immediately (asynchronous).
2. Push rd=5/0x12345678, then rd=31/0xAABBCCDD on consecutive cycles, wb_stall=0: RegW=1 with Rd=5, Wd=0x12345678 in the cycle after the first push; Rd=31 the next cycle; count returns to 0.
3. Push rd=0/0xDEADBEEF: handshake completes, count stays 0, RegW never asserts.
4. wb_stall=1 and push 4 entries: count=4 and in_ready=0. Then wb_stall=0 with in_valid=1: same-edge push and pop, count stays 4, drain order equals push order.
5. Queue rd=7/0x11 then rd=7/0x22 under stall, q_rs1=7, q_rs2=0: q_hit1=1 with fwd_data1=0x22; q_hit2=0 with fwd_data2=0. After the queue drains, q_hit1=0.
6. Wrap-around: push and drain 10 entries with random stalls, with a scoreboard comparing the RegFile write sequence against the push sequence (x0 entries removed). All match and count never exceeds 4.

Source files
------------

// File: rtl/regfile_wb_queue_pkg.sv
// Shared widths and entry type for the RegFile write-back queue.
package regfile_wb_queue_pkg;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS);
  localparam int unsigned DATA_W   = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wbq_entry_t;
endpackage

// File: rtl/regfile_wb_queue_if.sv
// Push handshake from execute/load units plus the RegFile write port.
interface regfile_wb_queue_if #(
  parameter int unsigned ADDR_W = regfile_wb_queue_pkg::ADDR_W,
  parameter int unsigned DATA_W = regfile_wb_queue_pkg::DATA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rd;
  logic [DATA_W-1:0] in_data;
  logic              wb_stall;
  logic              RegW;
  logic [ADDR_W-1:0] Rd;
  logic [DATA_W-1:0] Wd;

  modport master (
    output in_valid, in_rd, in_data, wb_stall,
    input  in_ready, RegW, Rd, Wd
  );

  modport slave (
    input  in_valid, in_rd, in_data, wb_stall,
    output in_ready, RegW, Rd, Wd
  );
endinterface

// File: rtl/regfile_wb_queue_match.sv
// Pending-write lookup: hit if any valid entry targets q_rs, data from the youngest match.
module wbq_match
  import regfile_wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  wbq_entry_t         entries [DEPTH],
  input  logic [DEPTH-1:0]   valid,
  input  logic [PTR_W-1:0]   head,
  input  logic [ADDR_W-1:0]  q_rs,
  output logic               hit,
  output logic [DATA_W-1:0]  data
);
  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match seen is the one nearest tail.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (valid[idx] && (entries[idx].rd == q_rs) && (q_rs != ZERO_REG)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end
endmodule

// File: rtl/regfile_wb_queue.sv
// In-order write-back FIFO draining onto the RegFile write port, with pending-write forwarding.
module regfile_wb_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = regfile_wb_queue_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_wb_queue_pkg::ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_wb_queue_if.slave      wb,
  input  logic [ADDR_W-1:0]      q_rs1,
  input  logic [ADDR_W-1:0]      q_rs2,
  output logic                   q_hit1,
  output logic                   q_hit2,
  output logic [DATA_W-1:0]      fwd_data1,
  output logic [DATA_W-1:0]      fwd_data2,
  output logic [$clog2(DEPTH):0] count
);
  import regfile_wb_queue_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  wbq_entry_t       mem_q [DEPTH];
  wbq_entry_t       mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic not_empty;
  logic pop;
  logic push;

  assign not_empty   = (count_q != '0);
  assign pop         = not_empty && !wb.wb_stall;
  assign wb.RegW     = pop;
  assign wb.Rd       = not_empty ? mem_q[head_q].rd   : '0;
  assign wb.Wd       = not_empty ? mem_q[head_q].data : '0;
  assign wb.in_ready = (count_q < FULL_CNT) || pop;
  // x0 results complete the handshake but never occupy a slot.
  assign push        = wb.in_valid && wb.in_ready && (wb.in_rd != ZERO_REG);
  assign count       = count_q;

  // Pop is applied before push so a full-queue swap (tail == head) leaves the slot valid.
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (push) begin
      mem_d[tail_q]   = '{rd: wb.in_rd, data: wb.in_data};
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q   <= '{default: '0};
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  wbq_match #(.DEPTH(DEPTH)) u_match1 (
    .entries (mem_q),
    .valid   (valid_q),
    .head    (head_q),
    .q_rs    (q_rs1),
    .hit     (q_hit1),
    .data    (fwd_data1)
  );

  wbq_match #(.DEPTH(DEPTH)) u_match2 (
    .entries (mem_q),
    .valid   (valid_q),
    .head    (head_q),
    .q_rs    (q_rs2),
    .hit     (q_hit2),
    .data    (fwd_data2)
  );
endmodule
